// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one add/sub/and/or datapath through a
// round-robin arbiter feeding a single registered result stage.
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   reqN_valid/ready/op/a/b      requester N handshake and payload (N = 0, 1)
//   rsp_valid/ready              result handshake (valid while result held)
//   rsp_id, rsp_result           owner and value of the held result
//   rsp_zero/cout/overflow       flags of the held result
module alu_arbiter #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_cout,
    output logic             rsp_overflow
);

    localparam int unsigned MSB  = WIDTH - 1;
    localparam int unsigned SUMW = WIDTH + 1;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_ptr;       // 1: requester 1 wins a tie
    logic             r_id;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_cout;
    logic             r_ovf;

    logic             w_can_accept;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_xfer;
    logic [1:0]       w_op;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_res;
    logic             w_cout;
    logic             w_ovf;

    // Arbitration: accept when empty or when the held result drains this cycle
    always_comb begin
        w_can_accept = rst_n && ((r_state == IDLE) || rsp_ready);
        w_gnt1       = req1_valid && (!req0_valid || r_ptr);
        w_gnt0       = req0_valid && !w_gnt1;
        req0_ready   = w_can_accept && w_gnt0;
        req1_ready   = w_can_accept && w_gnt1;
        w_xfer       = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    end

    // Operand select and shared datapath; subtract is a + ~b + 1
    always_comb begin
        w_op    = w_gnt1 ? req1_op : req0_op;
        w_a     = w_gnt1 ? req1_a  : req0_a;
        w_b     = w_gnt1 ? req1_b  : req0_b;
        w_cin   = (w_op == OP_SUB);
        w_b_eff = w_cin ? ~w_b : w_b;
        w_sum   = {1'b0, w_a} + {1'b0, w_b_eff} + SUMW'(w_cin);
        w_res   = w_sum[WIDTH-1:0];
        w_cout  = 1'b0;
        w_ovf   = 1'b0;
        case (w_op)
            OP_ADD, OP_SUB: begin
                w_res  = w_sum[WIDTH-1:0];
                w_cout = w_sum[WIDTH];
                // Overflow when the effective addends agree in sign and the sum does not
                w_ovf  = (w_a[MSB] == w_b_eff[MSB]) && (w_res[MSB] != w_a[MSB]);
            end
            OP_AND:  w_res = w_a & w_b;
            OP_OR:   w_res = w_a | w_b;
            default: w_res = w_sum[WIDTH-1:0];
        endcase
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (w_xfer) w_state_next = HOLD;
            HOLD: begin
                if (w_xfer)         w_state_next = HOLD;
                else if (rsp_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State, pointer and result register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_ptr    <= 1'b0;
            r_id     <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_xfer) begin
                r_ptr    <= w_gnt0;
                r_id     <= w_gnt1;
                r_result <= w_res;
                r_zero   <= ~|w_res;
                r_cout   <= w_cout;
                r_ovf    <= w_ovf;
            end
        end
    end

    assign rsp_valid    = (r_state == HOLD);
    assign rsp_id       = r_id;
    assign rsp_result   = r_result;
    assign rsp_zero     = r_zero;
    assign rsp_cout     = r_cout;
    assign rsp_overflow = r_ovf;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: cycle model of arbiter + result stage, scoreboard of
// expected responses, table of directed ALU vectors and multi-cycle sequences.
module tb_alu_arbiter;

    localparam int unsigned W = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req0_ready;
    logic [1:0]   req0_op;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready;
    logic [1:0]   req1_op;
    logic [W-1:0] req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_id;
    logic [W-1:0] rsp_result;
    logic         rsp_zero, rsp_cout, rsp_overflow;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_cout(rsp_cout),
        .rsp_overflow(rsp_overflow)
    );

    typedef struct {
        logic         id;
        logic [W-1:0] result;
        logic         zero;
        logic         cout;
        logic         ovf;
    } rsp_t;

    typedef struct {
        logic         id;
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] e_res;
        logic         e_zero;
        logic         e_cout;
        logic         e_ovf;
    } vec_t;

    rsp_t exp_q[$];
    vec_t vecs[8];
    int   n_cmp = 0;
    int   n_fail = 0;
    logic m_state = 1'b0;
    logic m_ptr = 1'b0;
    logic use_tbl = 1'b0;
    rsp_t tbl_rsp;
    logic acc0, acc1;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic rsp_t model_alu(input logic id, input logic [1:0] op,
                                       input logic [W-1:0] a, input logic [W-1:0] b);
        rsp_t         r;
        logic [W:0]   full;
        r.id   = id;
        r.cout = 1'b0;
        r.ovf  = 1'b0;
        case (op)
            2'b00: begin
                full     = {1'b0, a} + {1'b0, b};
                r.result = full[W-1:0];
                r.cout   = full[W];
                r.ovf    = (a[W-1] == b[W-1]) && (r.result[W-1] != a[W-1]);
            end
            2'b01: begin
                full     = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
                r.result = full[W-1:0];
                r.cout   = full[W];
                r.ovf    = (a[W-1] != b[W-1]) && (r.result[W-1] != a[W-1]);
            end
            2'b10:   r.result = a & b;
            default: r.result = a | b;
        endcase
        r.zero = (r.result == '0);
        return r;
    endfunction

    // One clock: check readies and held response against the model, then advance it
    task automatic cycle();
        logic can, g0, g1;
        rsp_t f, n;
        #1;
        can = rst_n && (!m_state || rsp_ready);
        g1  = req1_valid && (!req0_valid || m_ptr);
        g0  = req0_valid && !g1;
        acc0 = can && g0;
        acc1 = can && g1;
        chk1("req0_ready", req0_ready, acc0);
        chk1("req1_ready", req1_ready, acc1);
        chk1("rsp_valid", rsp_valid, m_state);
        if (m_state && exp_q.size() > 0) begin
            f = exp_q[0];
            chk1("rsp_id", rsp_id, f.id);
            chkw("rsp_result", rsp_result, f.result);
            chk1("rsp_zero", rsp_zero, f.zero);
            chk1("rsp_cout", rsp_cout, f.cout);
            chk1("rsp_overflow", rsp_overflow, f.ovf);
        end
        if (!rst_n) begin
            m_state = 1'b0;
            m_ptr   = 1'b0;
            exp_q.delete();
        end else begin
            if (m_state && rsp_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (acc0 || acc1) begin
                if (use_tbl) n = tbl_rsp;
                else if (acc1) n = model_alu(1'b1, req1_op, req1_a, req1_b);
                else n = model_alu(1'b0, req0_op, req0_a, req0_b);
                exp_q.push_back(n);
                m_state = 1'b1;
                m_ptr   = acc0;
            end else if (m_state && rsp_ready) begin
                m_state = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        #1;
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk1("rst_rsp_id", rsp_id, 1'b0);
        chkw("rst_rsp_result", rsp_result, '0);
        chk1("rst_rsp_zero", rsp_zero, 1'b0);
        chk1("rst_rsp_cout", rsp_cout, 1'b0);
        chk1("rst_rsp_overflow", rsp_overflow, 1'b0);
    endtask

    task automatic new_payload0();
        req0_op = 2'($urandom_range(0, 3));
        req0_a  = W'({$urandom, $urandom});
        req0_b  = W'({$urandom, $urandom});
    endtask

    task automatic new_payload1();
        req1_op = 2'($urandom_range(0, 3));
        req1_a  = W'({$urandom, $urandom});
        req1_b  = W'({$urandom, $urandom});
    endtask

    initial begin
        vecs[0] = '{1'b0, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 2'b01, 64'h1234, 64'h1234, 64'h0, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 2'b10, 64'hF0F0, 64'h0FF0, 64'h00F0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 2'b11, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 2'b01, 64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 2'b01, 64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 2'b00, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0, 1'b1, 1'b1, 1'b1};

        // Reset with both requesters asserting: no readies
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        new_payload0(); new_payload1();
        @(posedge clk); #1;
        cycle();
        cycle();
        rst_n = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        check_reset_outputs();

        // Directed ALU vectors, back-to-back with a free consumer
        use_tbl = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tbl_rsp = '{vecs[i].id, vecs[i].e_res, vecs[i].e_zero, vecs[i].e_cout, vecs[i].e_ovf};
            req0_valid = !vecs[i].id;
            req1_valid = vecs[i].id;
            req0_op = vecs[i].op; req0_a = vecs[i].a; req0_b = vecs[i].b;
            req1_op = vecs[i].op; req1_a = vecs[i].a; req1_b = vecs[i].b;
            cycle();
        end
        use_tbl = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        cycle();
        cycle();

        // Contention from reset: grants alternate 0,1,0,1
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        check_reset_outputs();
        req0_valid = 1'b1; req1_valid = 1'b1;
        new_payload0(); new_payload1();
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (acc0) new_payload0();
            if (acc1) new_payload1();
        end

        // Backpressure: result held for 3 cycles, then drained with a same-cycle accept
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        rsp_ready = 1'b1;
        cycle();
        if (acc0) new_payload0();
        if (acc1) new_payload1();
        req0_valid = 1'b0; req1_valid = 1'b0;
        cycle();
        cycle();

        // Reset while holding a result; pointer returns to requester 0
        req0_valid = 1'b1;
        new_payload0();
        rsp_ready = 1'b0;
        cycle();
        req0_valid = 1'b0;
        cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        check_reset_outputs();
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        new_payload0(); new_payload1();
        cycle();
        chk1("post_reset_grant0", acc0, 1'b1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        cycle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, default 64, operand/result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_op  input  2  requester 0 opcode: 00 add, 01 sub, 10 and, 11 or.
REQ-007 req0_a, req0_b  input  WIDTH each  requester 0 operands.
REQ-008 req1_valid, req1_ready, req1_op, req1_a, req1_b  same directions/widths/meanings as requester 0 ports, for requester 1.
REQ-009 rsp_valid  output  1  result register holds an unconsumed result.
REQ-010 rsp_ready  input  1  consumer accepts the result this cycle.
REQ-011 rsp_id  output  1  requester index that owns the result.
REQ-012 rsp_result  output  WIDTH  operation result.
REQ-013 rsp_zero, rsp_cout, rsp_overflow  output  1 each  result==0; carry out; signed overflow.

Function
REQ-014 The block SHALL share one add/sub/and/or datapath between two requesters, with a registered result stage and valid/ready handshakes on both sides.
REQ-015 States SHALL be IDLE (result register empty) and HOLD (result register full); rsp_valid is 1 exactly in HOLD.
REQ-016 Accept condition: can_accept = (state==IDLE) or (state==HOLD and rsp_ready).
REQ-017 Grant: only requesters with valid=1 are eligible; if both are eligible, the requester named by the round-robin pointer wins.
REQ-018 reqN_ready SHALL be 1 only when can_accept and requester N is granted; at most one ready per cycle; ready never asserts without the matching valid.
REQ-019 A transfer occurs when reqN_valid and reqN_ready are both 1; on that edge the result register loads result, flags and rsp_id=N; the state becomes HOLD.
REQ-020 Latency: a request transferred at edge k SHALL appear with rsp_valid=1 in the cycle following edge k (one cycle).
REQ-021 On a transfer, the pointer SHALL move to the non-granted requester; with no transfer, the pointer holds.
REQ-022 In HOLD with rsp_ready=0, rsp_result, rsp_id and all flags SHALL stay stable and both readies SHALL be 0.
REQ-023 In HOLD, if rsp_ready=1 and no transfer occurs, the state returns to IDLE; if a transfer occurs, the state stays HOLD with new contents (back-to-back, one result per cycle).
REQ-024 Add: result = a+b mod 2^WIDTH; cout = carry out of bit WIDTH-1; overflow = operands' signs equal and result sign differs.
REQ-025 Sub: result = a + ~b + 1 mod 2^WIDTH; cout = carry out of that sum (1 = no borrow); overflow = operands' signs differ and result sign differs from a.
REQ-026 And/or: bitwise result; cout=0, overflow=0.
REQ-027 rsp_zero = 1 iff all result bits are 0, for every opcode.
REQ-028 A requester SHALL hold valid and payload until ready; the block does not sample payload on any other cycle.

Reset
REQ-029 When rst_n=0 at a rising edge: state IDLE, pointer = requester 0, rsp_valid=0, rsp_id=0, rsp_result=0, all flags 0.
REQ-030 Reset during HOLD SHALL discard the held result with no response; readies are 0 while rst_n=0.
REQ-031 The first cycle with rst_n=1 after reset SHALL accept requests normally.

Verification
REQ-032 Single add: req0 add a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> next cycle rsp_valid=1, id=0, result=0x8000_0000_0000_0000, overflow=1, cout=0, zero=0.
REQ-033 Sub to zero: req1 sub a=b=0x1234 -> result=0, zero=1, cout=1, overflow=0, id=1.
REQ-034 Contention: both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1 from reset; one rsp per cycle, ids 0,1,0,1.
REQ-035 Backpressure: rsp_ready=0 for 3 cycles with result held -> result/flags/id stable, both readies 0; rsp_ready=1 -> next pending request accepted that same cycle.
REQ-036 Logic ops: and 0xF0F0 & 0x0FF0 -> 0x00F0, cout=0, overflow=0; or 0 | 0 -> 0, zero=1.
REQ-037 Reset mid-HOLD: rst_n=0 one edge while rsp_valid=1 -> rsp_valid=0, outputs 0, pointer=0; next simultaneous request grants requester 0.
